// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serial framer and its neighbours.
// Optional parity bit is enabled by defining PARITY_SER_EN.
package seq_serializer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SHIFT  = 2'b01;
  localparam logic [1:0] ST_PARITY = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY
  } state_t;

  // Number of serial bits emitted per accepted word.
  function automatic int frame_len(input int width);
`ifdef PARITY_SER_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/seq_serializer_bit_counter.sv
// Modulo-WIDTH bit index counter with a flag marking the last index.
module ser_bit_counter
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_reg;

  assign last = (cnt_reg == CW'(WIDTH - 1));
  assign cnt  = cnt_reg;

  // Advance while enabled, wrapping to 0 after the last bit index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= last ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial framer feeding a sequence detector's serial input.
// Words are taken over valid/ready and shifted out one bit per clock with
// framing flags. Define PARITY_SER_EN to append an even-parity bit per word.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             Data_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             data_out_reg, data_out_next;
  logic             bit_valid_reg, bit_valid_next;
  logic             frame_start_reg, frame_start_next;
  logic             frame_end_reg, frame_end_next;
`ifdef PARITY_SER_EN
  logic             parity_reg, parity_next;
`endif
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             cnt_en;
  logic             accept;
  logic             load;

  // Bit that leaves the word first, and the word after one bit has left.
  function automatic logic pick_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // cnt is the index of the data bit currently on Data_out.
  ser_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // Ready whenever the next edge could start a new frame without a gap.
  always_comb begin
    din_ready = 1'b0;
    case (state_reg)
      IDLE:   din_ready = 1'b1;
`ifdef PARITY_SER_EN
      PARITY: din_ready = 1'b1;
`else
      SHIFT:  din_ready = cnt_last;
`endif
      default: din_ready = 1'b0;
    endcase
  end

  assign accept = din_valid & din_ready;

  // Next-state and next-output logic; outputs fall to 0 unless a bit is due.
  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    data_out_next    = 1'b0;
    bit_valid_next   = 1'b0;
    frame_start_next = 1'b0;
    frame_end_next   = 1'b0;
`ifdef PARITY_SER_EN
    parity_next      = parity_reg;
`endif
    cnt_en           = 1'b0;
    load             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      SHIFT: begin
        cnt_en = 1'b1;
        if (!cnt_last) begin
          data_out_next  = pick_bit(shift_reg);
          shift_next     = shift_one(shift_reg);
          bit_valid_next = 1'b1;
`ifndef PARITY_SER_EN
          frame_end_next = (cnt == CW'(WIDTH - 2));
`endif
        end else begin
`ifdef PARITY_SER_EN
          state_next     = PARITY;
          data_out_next  = parity_reg;
          bit_valid_next = 1'b1;
          frame_end_next = 1'b1;
`else
          if (accept) load = 1'b1;
          else        state_next = IDLE;
`endif
        end
      end
`ifdef PARITY_SER_EN
      PARITY: begin
        if (accept) load = 1'b1;
        else        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase

    // A new word shows its first bit right after the accepting edge.
    if (load) begin
      state_next       = SHIFT;
      data_out_next    = pick_bit(din);
      shift_next       = shift_one(din);
      bit_valid_next   = 1'b1;
      frame_start_next = 1'b1;
      frame_end_next   = 1'b0;
`ifdef PARITY_SER_EN
      parity_next      = ^din;
`endif
    end
  end

  // State, shift register and registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      data_out_reg    <= 1'b0;
      bit_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
`ifdef PARITY_SER_EN
      parity_reg      <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      data_out_reg    <= data_out_next;
      bit_valid_reg   <= bit_valid_next;
      frame_start_reg <= frame_start_next;
      frame_end_reg   <= frame_end_next;
`ifdef PARITY_SER_EN
      parity_reg      <= parity_next;
`endif
    end
  end

  assign Data_out    = data_out_reg;
  assign bit_valid   = bit_valid_reg;
  assign frame_start = frame_start_reg;
  assign frame_end   = frame_end_reg;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed, table-driven bench for seq_serializer (WIDTH=4).
// Expectations follow PARITY_SER_EN when it is defined.
module tb_seq_serializer;
  import seq_serializer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready, dout, bv, fs, fe;
  logic [3:0] din2;
  logic       dv2;
  logic       rdy2, dout2, bv2, fs2, fe2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .Data_out(dout), .bit_valid(bv), .frame_start(fs), .frame_end(fe)
  );

  seq_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din2), .din_valid(dv2), .din_ready(rdy2),
    .Data_out(dout2), .bit_valid(bv2), .frame_start(fs2), .frame_end(fe2)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] din;
    logic       dv;
    logic       rdy;   // din_ready expected before the edge
    logic       dout;  // outputs expected after the edge
    logic       bv;
    logic       fs;
    logic       fe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] d, input logic v,
                              input logic rd, input logic o, input logic b,
                              input logic s, input logic e);
    vec_t t;
    t.rst = r; t.din = d; t.dv = v; t.rdy = rd;
    t.dout = o; t.bv = b; t.fs = s; t.fe = e;
    return t;
  endfunction

  task automatic check(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    logic [3:0] lsb_exp;
    int         cnt;
    int         guard;

    rst = 1'b0; din = '0; din_valid = 1'b0; din2 = '0; dv2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.dout", dout, 1'b0);
    check("reset.bv", bv, 1'b0);
    check("reset.fs", fs, 1'b0);
    check("reset.fe", fe, 1'b0);
    check("reset.ready", din_ready, 1'b1);
    $display("reset: dout=%b bv=%b fs=%b fe=%b ready=%b", dout, bv, fs, fe, din_ready);
    @(negedge clk);
    rst = 1'b1;

`ifdef PARITY_SER_EN
    // single word 1011: bits 1,0,1,1 then parity 1
    tbl.push_back(mk(1, 4'b1011, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
    // back-to-back 1010 (parity 0), 1100 (parity 0)
    tbl.push_back(mk(1, 4'b1010, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b1100, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b1100, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b1100, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b1100, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b1100, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
    // busy: 4'hF offered while a frame is in flight, then dropped
    tbl.push_back(mk(1, 4'b1011, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
    // 1001: parity bit 0
    tbl.push_back(mk(1, 4'b1001, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
`else
    // single word 1011: bits 1,0,1,1
    tbl.push_back(mk(1, 4'b1011, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
    // back-to-back 1010 then 1100, no gap
    tbl.push_back(mk(1, 4'b1010, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b1100, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b1100, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b1100, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b1100, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
    // busy: 4'hF offered while a frame is in flight, then dropped
    tbl.push_back(mk(1, 4'b1011, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
    // 1001
    tbl.push_back(mk(1, 4'b1001, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
`endif
    // reset mid-frame, then reset together with din_valid
    tbl.push_back(mk(1, 4'b1011, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; din = tbl[i].din; din_valid = tbl[i].dv;
      #1;
      check($sformatf("v%0d.ready", i), din_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.dout", i), dout, tbl[i].dout);
      check($sformatf("v%0d.bv", i), bv, tbl[i].bv);
      check($sformatf("v%0d.fs", i), fs, tbl[i].fs);
      check($sformatf("v%0d.fe", i), fe, tbl[i].fe);
      $display("v%0d: rst=%b din=%b dv=%b -> ready=%b dout=%b bv=%b fs=%b fe=%b",
               i, tbl[i].rst, tbl[i].din, tbl[i].dv, din_ready, dout, bv, fs, fe);
    end

    // LSB-first instance: 1011 leaves as 1,1,0,1
    lsb_exp = 4'b1011;
    @(negedge clk);
    din2 = 4'b1011; dv2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        dv2 = 1'b0;
      end
      @(posedge clk);
      #1;
      check($sformatf("lsb%0d.dout", i), dout2, lsb_exp[i]);
      check($sformatf("lsb%0d.bv", i), bv2, 1'b1);
      check($sformatf("lsb%0d.fs", i), fs2, (i == 0));
      check($sformatf("lsb%0d.fe", i), fe2, (i == frame_len(4) - 1));
      $display("lsb bit %0d: dout=%b bv=%b fs=%b fe=%b", i, dout2, bv2, fs2, fe2);
    end
`ifdef PARITY_SER_EN
    @(posedge clk);
    #1;
    check("lsb.parity", dout2, 1'b1);
    check("lsb.parity_fe", fe2, 1'b1);
    $display("lsb parity: dout=%b fe=%b", dout2, fe2);
`endif
    @(posedge clk);
    #1;
    check("lsb.idle_bv", bv2, 1'b0);
    check("lsb.idle_dout", dout2, 1'b0);
    $display("lsb idle: dout=%b bv=%b", dout2, bv2);

    // Frame length measured as the run of bit_valid cycles, bounded
    @(negedge clk);
    din = 4'b0110; din_valid = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    guard = 0;
    while (bv === 1'b1 && guard < 20) begin
      cnt++;
      guard++;
      @(negedge clk);
      din_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    check_int("frame_len.timeout", guard < 20 ? 0 : 1, 0);
    check_int("frame_len", cnt, frame_len(4));
    $display("frame length: %0d bits", cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial framer that directly feeds a sequence detector's serial Data_in.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- Flags bit validity and frame boundaries so detector hits can be attributed to a word.
- Back-to-back words produce a gap-free bit stream, so patterns spanning word boundaries (overlap) are preserved.

Parameters:
WIDTH, 8, data word width in bits (>=2)
MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = bit 0 first

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-low reset
din  input  WIDTH  parallel word
din_valid  input  1  din holds a word to send
din_ready  output  1  block can accept a word this cycle
Data_out  output  1  serial bit, connects to detector Data_in
bit_valid  output  1  Data_out carries a real data/parity bit
frame_start  output  1  Data_out is first bit of a word
frame_end  output  1  Data_out is last bit of a frame (data or parity)

Behaviour:
- Interface: one clock; reset is synchronous and active-low. rst=0 sampled at a clk edge → state IDLE, shift register 0, bit counter 0, Data_out=0, bit_valid=0, frame_start=0, frame_end=0.
- State machine:
  - IDLE: din_ready=1. On accept (din_valid & din_ready), load din into the shift register and go to SHIFT.
  - SHIFT: emits WIDTH bits, one per cycle.
  - PARITY (PARITY_SER_EN only): emits one extra bit.
- Registered outputs:
  - Data_out, bit_valid, frame_start and frame_end are registered.
  - For a word accepted at edge k, its first bit appears after edge k, i.e. during cycle k+1. Latency = 1 cycle.
  - The last data bit appears during cycle k+WIDTH.
- din_ready (combinational from state/counter):
  - 1 in IDLE.
  - 1 in SHIFT while the last data bit is on Data_out (no parity configured).
  - 1 in PARITY (parity configured).
  - 0 otherwise.
  - An accept in that last cycle reloads the shift register, so the next word's first bit follows with zero idle cycles.
- Bit order:
  - MSB_FIRST=1: Data_out = shift register MSB; shift left, fill 0.
  - MSB_FIRST=0: Data_out = shift register LSB; shift right, fill 0.
- Bit counter: $clog2(WIDTH) bits, counts 0..WIDTH-1 and wraps to 0 on the last bit. No other wrap.
- Idle output: when no word is in flight, Data_out=0 and bit_valid=0. The downstream detector sees 0s, which return a 1011-type detector toward its start state.
- frame_start=1 only with bit index 0. frame_end=1 only with the final bit of the frame. For WIDTH>=2 the two are never both 1.
- din_valid while din_ready=0: ignored. din is not sampled. The upstream must hold din and din_valid until accepted.
- Reset mid-word: the word is discarded, outputs go to 0 next cycle, and no partial frame_end is produced.
- Reset and din_valid together: reset wins; nothing is accepted.

Optional Feature:
- Macro: PARITY_SER_EN.
- Defined:
  - After the WIDTH data bits, one even-parity bit (XOR of the accepted word) is emitted with bit_valid=1.
  - frame_end moves to the parity bit.
  - din_ready is asserted in the parity cycle instead of the last data cycle.
  - Frame length = WIDTH+1.
- Undefined: no PARITY state and no parity register. Frame length = WIDTH.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10;
  - a function returning the frame length (WIDTH or WIDTH+1).
- The detector and the serializer testbench reuse the package.
- One natural sub-module: ser_bit_counter, a parameterised modulo-WIDTH counter with a last-bit flag output.
- The FSM and shift register stay in the top module.

Test Plan (WIDTH=4 unless stated):
- Reset, then din=4'b1011 with din_valid pulsed 1 cycle, MSB_FIRST=1 → Data_out 1,0,1,1 on cycles 1-4; bit_valid=1 for those 4 cycles; frame_start on cycle 1, frame_end on cycle 4; then Data_out=0, bit_valid=0.
- Back-to-back: 4'b1010 then 4'b1100 with din_valid held → 8 consecutive bit_valid cycles 1,0,1,0,1,1,0,0; din_ready high only in IDLE and on cycles 4 and 8.
- Busy: din_valid=1, din=4'hF asserted during cycle 2 of a frame and dropped before the last bit → not accepted; the stream is unchanged.
- Reset mid-frame: assert rst=0 at cycle 2 → next cycle all outputs 0; IDLE with din_ready=1; no frame_end emitted.
- MSB_FIRST=0, din=4'b1011 → Data_out 1,1,0,1.
- PARITY_SER_EN defined, din=4'b1011 → 5 bits 1,0,1,1,1; frame_end on the 5th bit; din=4'b1001 → parity bit 0.
